// File: rtl/post_adder_acc_pkg.sv
// dsp_pkg: definitions shared by the post-multiplier add/accumulate stage.
//   - OP_* : OPMODE encodings (LOAD, ACC, ADDC, SUBC)
//   - state_e : burst state (idle, accumulating, holding a result)
//   - DEFAULT_WIDTH : default datapath width
package dsp_pkg;

    localparam int DEFAULT_WIDTH = 48;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_ADDC = 2'b10;
    localparam logic [1:0] OP_SUBC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/post_adder_acc_alu.sv
// alu_add_sub: combinational add/subtract for the accumulate stage.
// Ports:
//   opmode_i  - OP_LOAD / OP_ACC / OP_ADDC / OP_SUBC
//   a_i       - product from the multiplier
//   b_i       - C operand
//   acc_i     - current accumulator value
//   sum_o     - WIDTH-bit wrapped result
//   carry_o   - unsigned carry out (inverted borrow for SUBC)
//   ovf_o     - signed overflow of this operation
module alu_add_sub
    import dsp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       opmode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH:0]   full;

    // Every mode is folded into one adder x + y + cin; SUBC is x + ~a + 1,
    // so the adder carry out is directly the inverted borrow.
    always_comb begin
        x   = '0;
        y   = a_i;
        cin = 1'b0;
        case (opmode_i)
            OP_LOAD: begin x = '0;    y = a_i;  cin = 1'b0; end
            OP_ACC:  begin x = acc_i; y = a_i;  cin = 1'b0; end
            OP_ADDC: begin x = b_i;   y = a_i;  cin = 1'b0; end
            OP_SUBC: begin x = b_i;   y = ~a_i; cin = 1'b1; end
            default: begin x = '0;    y = a_i;  cin = 1'b0; end
        endcase
        full    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        sum_o   = full[WIDTH-1:0];
        carry_o = full[WIDTH];
        // Same-sign addends with a differently signed result. With y = ~a
        // this is the subtraction rule (c and a of opposite sign).
        ovf_o   = (x[WIDTH-1] == y[WIDTH-1]) && (sum_o[WIDTH-1] != x[WIDTH-1]);
    end

endmodule

// File: rtl/post_adder_acc.sv
// post_adder_acc: DSP post-multiplier ALU plus P register with LAST-delimited
// bursts and a valid/ready result port.
// Ports:
//   clk_i, rstn_i            - clock, asynchronous active-low reset
//   prod_i, c_i, opmode_i    - beat operands and operation
//   last_i                   - final beat of the burst
//   prod_valid_i/prod_ready_o - input handshake (ready = !p_valid || p_ready)
//   p_o, carryout_o, overflow_o, beat_cnt_o - registered burst result
//   p_valid_o/p_ready_i      - output handshake
//   patterndetect_o          - only when PATTERN_DETECT_EN is defined
// Optional feature macro: PATTERN_DETECT_EN (adds PATTERN, MASK, patterndetect_o).
module post_adder_acc
    import dsp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
`ifdef PATTERN_DETECT_EN
    ,
    parameter logic [WIDTH-1:0] PATTERN = '0,
    parameter logic [WIDTH-1:0] MASK    = '0
`endif
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [1:0]       opmode_i,
    input  logic             last_i,
    input  logic             prod_valid_i,
    output logic             prod_ready_o,
    output logic [WIDTH-1:0] p_o,
    output logic             carryout_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] beat_cnt_o,
    output logic             p_valid_o,
    input  logic             p_ready_i
`ifdef PATTERN_DETECT_EN
    ,
    output logic             patterndetect_o
`endif
);

    state_e           state_q;
    logic             p_valid_q;

    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] p_q,      p_d;
    logic             carry_q,  carry_d;
    logic             ovf_q,    ovf_d;
    logic [CNT_W-1:0] bcnt_q,   bcnt_d;

    logic [WIDTH-1:0] alu_sum;
    logic             alu_carry;
    logic             alu_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat_acc;

    alu_add_sub #(.WIDTH(WIDTH)) u_alu (
        .opmode_i (opmode_i),
        .a_i      (prod_i),
        .b_i      (c_i),
        .acc_i    (acc_q),
        .sum_o    (alu_sum),
        .carry_o  (alu_carry),
        .ovf_o    (alu_ovf)
    );

    // No skid buffer: a held result blocks input unless it retires this edge.
    assign prod_ready_o = (state_q != ST_HOLD) || p_ready_i;
    assign beat_acc     = prod_valid_i && prod_ready_o;
    assign cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        acc_d    = acc_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        bcnt_d   = bcnt_q;
        if (beat_acc) begin
            if (last_i) begin
                // Publish the burst and leave the working state clean, so an
                // ACC on the next burst's first beat adds to zero.
                p_d      = alu_sum;
                carry_d  = alu_carry;
                ovf_d    = sticky_q | alu_ovf;
                bcnt_d   = cnt_inc;
                acc_d    = '0;
                sticky_d = 1'b0;
                cnt_d    = '0;
            end else begin
                acc_d    = alu_sum;
                sticky_d = sticky_q | alu_ovf;
                cnt_d    = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            bcnt_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            bcnt_q   <= bcnt_d;
        end
    end

    // Burst FSM; p_valid is registered alongside the state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            p_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (beat_acc) begin
                        state_q   <= last_i ? ST_HOLD : ST_ACCUM;
                        p_valid_q <= last_i;
                    end
                end
                ST_HOLD: begin
                    if (beat_acc) begin
                        state_q   <= last_i ? ST_HOLD : ST_ACCUM;
                        p_valid_q <= last_i;
                    end else if (p_ready_i) begin
                        state_q   <= ST_IDLE;
                        p_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    p_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign p_o        = p_q;
    assign carryout_o = carry_q;
    assign overflow_o = ovf_q;
    assign beat_cnt_o = bcnt_q;
    assign p_valid_o  = p_valid_q;

`ifdef PATTERN_DETECT_EN
    logic pd_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pd_q <= 1'b0;
        end else if (beat_acc && last_i) begin
            pd_q <= (((alu_sum ^ PATTERN) & ~MASK) == '0);
        end
    end

    assign patterndetect_o = pd_q;
`endif

endmodule

// File: tb/tb_post_adder_acc.sv
module tb_post_adder_acc;

    localparam int W = 48;
    localparam logic [1:0] LD = 2'b00, AC = 2'b01, AD = 2'b10, SB = 2'b11;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] prod, c;
    logic [1:0]   opmode;
    logic         last, prod_valid, prod_ready;
    logic [W-1:0] p;
    logic         carryout, overflow, p_valid, p_ready;
    logic [7:0]   beat_cnt;
`ifdef PATTERN_DETECT_EN
    logic         patterndetect;
`endif

    post_adder_acc dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .prod_i       (prod),
        .c_i          (c),
        .opmode_i     (opmode),
        .last_i       (last),
        .prod_valid_i (prod_valid),
        .prod_ready_o (prod_ready),
        .p_o          (p),
        .carryout_o   (carryout),
        .overflow_o   (overflow),
        .beat_cnt_o   (beat_cnt),
        .p_valid_o    (p_valid),
        .p_ready_i    (p_ready)
`ifdef PATTERN_DETECT_EN
        ,
        .patterndetect_o (patterndetect)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: burst-level arithmetic on plain integers.
    logic [W-1:0] m_acc;
    bit           m_sticky;
    int           m_cnt;
    bit           m_pvalid;
    logic [W-1:0] m_p;
    bit           m_carry, m_ovf;
    int           m_bcnt;
    int           m_accepted, m_retired;

    function automatic longint sx(input logic [W-1:0] v);
        return longint'(signed'({{(64-W){v[W-1]}}, v}));
    endfunction

    localparam longint SMAX = (64'sd1 <<< (W-1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (W-1));

    task automatic model_reset();
        m_acc = '0; m_sticky = 0; m_cnt = 0; m_pvalid = 0;
        m_p = '0; m_carry = 0; m_ovf = 0; m_bcnt = 0;
    endtask

    task automatic model_step(input bit v, input bit l, input logic [1:0] op,
                              input logic [W-1:0] pr, input logic [W-1:0] cc, input bit rdy);
        logic [W:0]   u;
        longint       s;
        logic [W-1:0] res;
        bit           cy, ov;
        bit           accept;
        accept = v && (!m_pvalid || rdy);
        if (m_pvalid && rdy) m_retired++;
        if (!accept) begin
            if (rdy) m_pvalid = 0;
            return;
        end
        m_accepted++;
        case (op)
            LD:      begin u = {1'b0, pr};                s = sx(pr); end
            AC:      begin u = {1'b0, m_acc} + {1'b0, pr}; s = sx(m_acc) + sx(pr); end
            AD:      begin u = {1'b0, cc} + {1'b0, pr};    s = sx(cc) + sx(pr); end
            default: begin u = {1'b0, cc - pr};            s = sx(cc) - sx(pr); end
        endcase
        res = u[W-1:0];
        cy  = (op == SB) ? (cc >= pr) : u[W];
        ov  = (s > SMAX) || (s < SMIN);
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        if (l) begin
            m_p = res; m_carry = cy; m_ovf = m_sticky | ov; m_bcnt = m_cnt;
            m_acc = '0; m_sticky = 0; m_cnt = 0; m_pvalid = 1;
            $display("result: p=%h carry=%0d ovf=%0d beats=%0d", m_p, m_carry, m_ovf, m_bcnt);
        end else begin
            m_acc = res; m_sticky = m_sticky | ov; m_pvalid = 0;
        end
    endtask

    task automatic compare_outputs();
        check("p_valid", p_valid, m_pvalid);
        if (m_pvalid) begin
            check("p", p, m_p);
            check("carryout", carryout, m_carry);
            check("overflow", overflow, m_ovf);
            check("beat_cnt", beat_cnt, m_bcnt);
`ifdef PATTERN_DETECT_EN
            check("patterndetect", patterndetect, (m_p == '0));
`endif
        end
    endtask

    // One clock cycle: drive, check ready, clock, advance model, compare.
    task automatic cyc(input bit v, input bit l, input logic [1:0] op,
                       input logic [W-1:0] pr, input logic [W-1:0] cc, input bit rdy);
        prod_valid = v; last = l; opmode = op; prod = pr; c = cc; p_ready = rdy;
        #1;
        check("prod_ready", prod_ready, !m_pvalid || rdy);
        @(posedge clk);
        model_step(v, l, op, pr, cc, rdy);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        prod_valid = 0; last = 0; p_ready = 0;
        rstn = 0;
        #2;
        model_reset();
        check("rst_p_valid", p_valid, 0);
        check("rst_p", p, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_carry", carryout, 0);
        check("rst_prod_ready", prod_ready, 1);
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    initial begin
        prod = '0; c = '0; opmode = LD; last = 0; prod_valid = 0; p_ready = 0;
        rstn = 0;
        m_accepted = 0; m_retired = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Reset mid-burst discards the partial burst.
        repeat (3) cyc(1, 0, AC, 48'd7, '0, 1);
        do_reset();
        cyc(1, 1, LD, 48'd5, '0, 0);
        check("rst_burst_p", p, 48'd5);
        check("rst_burst_cnt", beat_cnt, 8'd1);
        check("rst_burst_ovf", overflow, 0);

        // Accumulate burst, one-cycle latency.
        cyc(1, 0, AC, 48'd10, '0, 1);
        cyc(1, 0, AC, 48'd20, '0, 1);
        cyc(1, 1, AC, 48'd30, '0, 1);
        check("acc_p", p, 48'd60);
        check("acc_cnt", beat_cnt, 8'd3);
        check("acc_carry", carryout, 0);
        check("acc_valid", p_valid, 1);

        // SUBC both directions.
        cyc(1, 1, SB, 48'd150, 48'd100, 1);
        check("subc_neg_p", p, 48'hFFFF_FFFF_FFCE);
        check("subc_neg_carry", carryout, 0);
        cyc(1, 1, SB, 48'd100, 48'd150, 1);
        check("subc_pos_p", p, 48'd50);
        check("subc_pos_carry", carryout, 1);

        // Signed overflow, then cleared on the next burst.
        cyc(1, 0, LD, 48'h7FFF_FFFF_FFFF, '0, 1);
        cyc(1, 1, AC, 48'd1, '0, 1);
        check("ovf_p", p, 48'h8000_0000_0000);
        check("ovf_flag", overflow, 1);
        cyc(1, 1, LD, 48'd3, '0, 1);
        check("ovf_cleared", overflow, 0);

        // Pattern-detect results (P=0 then P=1).
        cyc(1, 1, AD, 48'd0, 48'd0, 1);
        check("zero_p", p, 48'd0);
        cyc(1, 1, LD, 48'd1, '0, 1);
        cyc(0, 0, LD, '0, '0, 1);

        // Backpressure: LAST every cycle, P_READY low for 4 cycles.
        begin
            int acc0, ret0, k;
            logic [W-1:0] held;
            acc0 = m_accepted; ret0 = m_retired; k = 0;
            cyc(1, 1, AD, rnd48(), rnd48(), 0);
            held = p;
            for (int i = 0; i < 4; i++) begin
                cyc(1, 1, AD, rnd48(), rnd48(), 0);
                check("bp_stall_ready", prod_ready, 0);
                check("bp_p_stable", p, held);
            end
            while ((m_accepted - acc0) < 10 && k < 40) begin
                cyc(1, 1, AD, rnd48(), rnd48(), 1);
                k++;
            end
            cyc(0, 0, LD, '0, '0, 1);
            check("bp_accepted", m_accepted - acc0, 10);
            check("bp_retired", m_retired - ret0, 10);
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit v, l, r;
            logic [W-1:0] a, b;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 9) < 7);
            a = rnd48();
            b = rnd48();
            if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) b = a;
            cyc(v, l, 2'($urandom_range(0, 3)), a, b, r);
        end

        // Long burst to exercise counter saturation.
        for (int i = 0; i < 259; i++) cyc(1, (i == 258), AC, W'($urandom_range(0, 1000)), '0, 1);
        check("sat_cnt", beat_cnt, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
